arbitro_barramento: RTL and testbench
=====================================

Name: arbitro_barramento

Overview:
- Upstream control stage for the shared tristate bus. Arbitrates bus ownership among N_FONTES sources.
- Drives the one-hot drive enables `ctrl[N_FONTES-1:0]`; bit i connects to bus input `ctrl_i`.
- Guarantees at most one driver at any time and inserts idle turnaround cycles between owners.
- Uses round-robin fairness and a bounded hold time.

Parameters:
- N_FONTES, 6, number of bus sources/drive enables.
- MAX_POSSE, 4, max consecutive cycles one owner holds the bus while another source is requesting (1..15).
- TURN_CICLOS, 1, all-enables-low cycles between two grants (1..3).
- LARG_DONO, 3, width of owner index; must satisfy 2^LARG_DONO >= N_FONTES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_FONTES  per-source bus request; level, held while the source wants the bus.
- ctrl  output  N_FONTES  registered one-hot-or-zero drive enables to the bus.
- ocupado  output  1  registered; high while any ctrl bit is high.
- dono  output  LARG_DONO  registered index of current owner; holds last owner when idle.
- troca  output  1  one-cycle pulse in the first cycle of every new grant.

Behaviour:
- Reset (async assert, sync-released by clk):
  - ctrl=0, ocupado=0, dono=0, troca=0.
  - State LIVRE, round-robin pointer ptr=0, hold counter cnt=0.
- All outputs are registered. No combinational path from req to ctrl.
- States:
  - LIVRE:
    - If req==0, stay.
    - Otherwise pick a winner by scanning from ptr upward, modulo N_FONTES; the first set bit wins.
    - Next edge: ctrl=onehot(w), dono=w, ocupado=1, troca=1, cnt=1, go POSSE.
    - Latency: req seen high at edge k gives ctrl high after edge k+1 (1 cycle).
  - POSSE:
    - ctrl holds onehot(dono). troca=0 after the first cycle.
    - cnt increments each cycle, saturating at MAX_POSSE.
    - Release when req[dono]==0, or when cnt==MAX_POSSE and any other req bit is set.
    - On release, next edge: ctrl=0, ocupado=0, ptr=(dono+1) mod N_FONTES, turnaround counter=TURN_CICLOS, go VIRADA.
    - If cnt==MAX_POSSE and no other request is pending, the owner keeps the bus indefinitely; cnt stays saturated.
  - VIRADA:
    - ctrl=0 for exactly TURN_CICLOS cycles. req is ignored for grant decisions.
    - At the last turnaround cycle, arbitrate as in LIVRE using the new ptr.
    - If a winner exists, go directly to POSSE (grant lands on the next edge). Otherwise go LIVRE.
- Boundaries:
  - Pointer wraps N_FONTES-1 -> 0.
  - A released owner still requesting is considered last in the next arbitration.
  - Simultaneous requests: round-robin from ptr decides.
  - req[dono] dropping in the same cycle cnt reaches MAX_POSSE is a normal release.
  - A request that appears and vanishes within LIVRE before the edge is not granted.
  - Reset mid-grant: ctrl goes 0 immediately (async).
  - Invariant: popcount(ctrl) <= 1 every cycle, and ctrl is never nonzero in two consecutive cycles with different owners.

Optional Feature:
- Macro: ARB_PRIORIDADE_FONTE0_EN
- Defined:
  - Source 0 has absolute priority. Any arbitration with req[0]=1 grants source 0 regardless of ptr.
  - When req[0] rises during another owner's POSSE, that owner is released on the next edge, ignoring MAX_POSSE, and the bus goes through VIRADA then to source 0.
  - Source 0 itself is never forced out by MAX_POSSE.
- Not defined: source 0 is an ordinary round-robin participant.

Test Plan:
- Reset then req=6'b000100 -> one cycle later ctrl=6'b000100, dono=2, troca=1 for one cycle, ocupado=1; during reset ctrl=0.
- req=6'b001001 held (defaults) -> grant source 0 for 4 cycles, 1 idle cycle, source 3 for 4 cycles, idle, source 0 ...; popcount(ctrl)<=1 every cycle.
- Single req=6'b100000 held 20 cycles -> ctrl=6'b100000 continuously after the first grant; no turnaround; cnt saturates.
- Owner 2 drops req after 2 cycles while req[4]=1 -> ctrl=0 one cycle, then ctrl=6'b010000; ptr=3 verified by simultaneous req[3],req[4] on the next arbitration, which grants 3.
- Assert rst_n=0 mid-POSSE, between clock edges -> ctrl=0 and ocupado=0 immediately; after release, arbitration restarts from ptr=0.
- With ARB_PRIORIDADE_FONTE0_EN: source 5 owns the bus, req[0] rises -> next edge ctrl=0, then ctrl=6'b000001. Without the macro, source 5 keeps the bus up to MAX_POSSE.

Source files
------------

// File: rtl/arbitro_barramento_if.sv
// ---------------------------------------------------------------------------
// arbitro_barramento_if
// Bundles the request/grant signals between the bus arbiter and the sources
// that share the tristate bus.
//   req     : per-source level request (sources -> arbiter)
//   ctrl    : one-hot-or-zero drive enables (arbiter -> bus)
//   ocupado : bus currently owned
//   dono    : index of current/last owner
//   troca   : one-cycle pulse on the first cycle of each grant
// Modports:
//   master : arbiter side (drives the grant signals)
//   slave  : source/bus side (drives req, observes the grant)
// ---------------------------------------------------------------------------
interface arbitro_barramento_if #(
    parameter int N_FONTES  = 6,
    parameter int LARG_DONO = 3
);
    logic [N_FONTES-1:0]  req;
    logic [N_FONTES-1:0]  ctrl;
    logic                 ocupado;
    logic [LARG_DONO-1:0] dono;
    logic                 troca;

    modport master (input req, output ctrl, output ocupado, output dono, output troca);
    modport slave  (output req, input ctrl, input ocupado, input dono, input troca);
endinterface

// File: rtl/arbitro_barramento.sv
// ---------------------------------------------------------------------------
// arbitro_barramento
// Round-robin owner arbiter for the shared tristate bus. Produces registered
// one-hot drive enables, limits how long one owner keeps the bus while others
// wait, and forces TURN_CICLOS all-off cycles between any two owners so two
// drivers never overlap.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : arbitro_barramento_if.master (req in; ctrl/ocupado/dono/troca out)
// Optional build macro:
//   ARB_PRIORIDADE_FONTE0_EN : source 0 gets absolute priority, pre-empts any
//                              other owner and is never forced out by the
//                              hold limit. Undefined: plain round-robin.
// ---------------------------------------------------------------------------
module arbitro_barramento #(
    parameter int N_FONTES    = 6,
    parameter int MAX_POSSE   = 4,   // 1..15
    parameter int TURN_CICLOS = 1,   // 1..3
    parameter int LARG_DONO   = 3    // 2**LARG_DONO >= N_FONTES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    arbitro_barramento_if.master bus
);

    typedef enum logic [1:0] {LIVRE, POSSE, VIRADA} estado_t;

    localparam logic [3:0]           CNT_MAX = 4'(MAX_POSSE);
    localparam logic [1:0]           VIR_INI = 2'(TURN_CICLOS);
    localparam logic [LARG_DONO-1:0] ULTIMA  = LARG_DONO'(N_FONTES - 1);

    estado_t              estado_q, estado_d;
    logic [LARG_DONO-1:0] ptr_q, ptr_d;
    logic [LARG_DONO-1:0] dono_q, dono_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [1:0]           vir_q, vir_d;
    logic [N_FONTES-1:0]  ctrl_q, ctrl_d;
    logic                 ocupado_q, ocupado_d;
    logic                 troca_q, troca_d;

    function automatic logic [N_FONTES-1:0] onehot(input logic [LARG_DONO-1:0] w);
        logic [N_FONTES-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // Winner search: first requesting source at or after ptr, wrapping.
    logic                 tem_venc;
    logic [LARG_DONO-1:0] venc;
    logic [LARG_DONO-1:0] cand;

    always_comb begin
        tem_venc = 1'b0;
        venc     = '0;
        cand     = '0;
        for (int i = 0; i < N_FONTES; i++) begin
            cand = LARG_DONO'((int'(ptr_q) + i) % N_FONTES);
            if (!tem_venc && bus.req[cand]) begin
                tem_venc = 1'b1;
                venc     = cand;
            end
        end
`ifdef ARB_PRIORIDADE_FONTE0_EN
        if (bus.req[0]) begin
            tem_venc = 1'b1;
            venc     = '0;
        end
`endif
    end

    // Release decision for the current owner.
    logic [N_FONTES-1:0] mask_dono;
    logic                dono_req;
    logic                outros;
    logic                liberar;

    always_comb begin
        mask_dono = onehot(dono_q);
        dono_req  = |(bus.req & mask_dono);
        outros    = |(bus.req & ~mask_dono);
`ifdef ARB_PRIORIDADE_FONTE0_EN
        // Source 0 can only leave voluntarily; anyone else yields to it at once.
        liberar = !dono_req ||
                  ((dono_q != '0) && (bus.req[0] || ((cnt_q == CNT_MAX) && outros)));
`else
        liberar = !dono_req || ((cnt_q == CNT_MAX) && outros);
`endif
    end

    always_comb begin
        estado_d  = estado_q;
        ptr_d     = ptr_q;
        dono_d    = dono_q;
        cnt_d     = cnt_q;
        vir_d     = vir_q;
        ctrl_d    = ctrl_q;
        ocupado_d = ocupado_q;
        troca_d   = 1'b0;

        case (estado_q)
            LIVRE: begin
                if (tem_venc) begin
                    estado_d  = POSSE;
                    ctrl_d    = onehot(venc);
                    dono_d    = venc;
                    ocupado_d = 1'b1;
                    troca_d   = 1'b1;
                    cnt_d     = 4'd1;
                end
            end
            POSSE: begin
                if (liberar) begin
                    estado_d  = VIRADA;
                    ctrl_d    = '0;
                    ocupado_d = 1'b0;
                    // Released owner goes to the back of the queue.
                    ptr_d     = (dono_q == ULTIMA) ? '0 : dono_q + 1'b1;
                    vir_d     = VIR_INI;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            VIRADA: begin
                // Arbitrate only in the last idle cycle so the new grant lands
                // exactly TURN_CICLOS cycles after the release.
                if (vir_q <= 2'd1) begin
                    if (tem_venc) begin
                        estado_d  = POSSE;
                        ctrl_d    = onehot(venc);
                        dono_d    = venc;
                        ocupado_d = 1'b1;
                        troca_d   = 1'b1;
                        cnt_d     = 4'd1;
                    end else begin
                        estado_d = LIVRE;
                    end
                end else begin
                    vir_d = vir_q - 2'd1;
                end
            end
            default: begin
                estado_d  = LIVRE;
                ctrl_d    = '0;
                ocupado_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= LIVRE;
            ptr_q     <= '0;
            dono_q    <= '0;
            cnt_q     <= '0;
            vir_q     <= '0;
            ctrl_q    <= '0;
            ocupado_q <= 1'b0;
            troca_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            ptr_q     <= ptr_d;
            dono_q    <= dono_d;
            cnt_q     <= cnt_d;
            vir_q     <= vir_d;
            ctrl_q    <= ctrl_d;
            ocupado_q <= ocupado_d;
            troca_q   <= troca_d;
        end
    end

    assign bus.ctrl    = ctrl_q;
    assign bus.ocupado = ocupado_q;
    assign bus.dono    = dono_q;
    assign bus.troca   = troca_q;

endmodule

// File: tb/tb_arbitro_barramento.sv
// ---------------------------------------------------------------------------
// tb_arbitro_barramento
// Directed vectors with hand-computed expectations for arbitro_barramento
// (N_FONTES=6, MAX_POSSE=4, TURN_CICLOS=1). Outputs are sampled 1 ns after
// the rising edge; every tick also checks the at-most-one-driver and
// no-direct-owner-swap invariants.
// ---------------------------------------------------------------------------
module tb_arbitro_barramento;

    logic clk = 1'b0;
    logic rst_n;

    arbitro_barramento_if #(.N_FONTES(6), .LARG_DONO(3)) bus ();

    arbitro_barramento #(
        .N_FONTES(6), .MAX_POSSE(4), .TURN_CICLOS(1), .LARG_DONO(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [5:0] prev_ctrl = '0;

    // Round-robin between sources 0 and 3 with both held.
    logic [5:0] rr_ctrl [11] = '{6'h01, 6'h01, 6'h01, 6'h01, 6'h00,
                                 6'h08, 6'h08, 6'h08, 6'h08, 6'h00, 6'h01};
    logic       rr_troca[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Source 5 owns the bus when req[0] rises.
`ifdef ARB_PRIORIDADE_FONTE0_EN
    logic [5:0] pr_ctrl [8] = '{6'h00, 6'h01, 6'h01, 6'h01,
                                6'h01, 6'h01, 6'h01, 6'h01};
`else
    logic [5:0] pr_ctrl [8] = '{6'h20, 6'h20, 6'h20, 6'h00,
                                6'h01, 6'h01, 6'h01, 6'h01};
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("popcount_le1", 32'($countones(bus.ctrl) <= 1), 32'd1);
        if (prev_ctrl != 6'h00 && bus.ctrl != 6'h00)
            chk("no_direct_swap", 32'(bus.ctrl), 32'(prev_ctrl));
        prev_ctrl = bus.ctrl;
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst_n   = 1'b0;
        tick();
        rst_n   = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.req = '0;
        tick();

        // Reset holds everything off even with a request present.
        bus.req = 6'b000100;
        tick();
        chk("rst_ctrl",    32'(bus.ctrl),    32'h0);
        chk("rst_ocupado", 32'(bus.ocupado), 32'h0);
        chk("rst_dono",    32'(bus.dono),    32'h0);
        chk("rst_troca",   32'(bus.troca),   32'h0);

        // First grant one edge after release.
        rst_n = 1'b1;
        tick();
        chk("g2_ctrl",    32'(bus.ctrl),    32'h04);
        chk("g2_dono",    32'(bus.dono),    32'd2);
        chk("g2_troca",   32'(bus.troca),   32'h1);
        chk("g2_ocupado", 32'(bus.ocupado), 32'h1);
        tick();
        chk("g2_hold",      32'(bus.ctrl),  32'h04);
        chk("g2_troca_end", 32'(bus.troca), 32'h0);

        // Short-lived request inside LIVRE is never granted.
        do_reset();
        bus.req = 6'b000010;
        #3;
        bus.req = 6'b000000;
        tick();
        chk("glitch_no_grant", 32'(bus.ctrl), 32'h0);

        // Sources 0 and 3 alternate, 4 cycles each, one idle cycle between.
        do_reset();
        bus.req = 6'b001001;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("rr_ctrl",  32'(bus.ctrl),  32'(rr_ctrl[i]));
            chk("rr_troca", 32'(bus.troca), 32'(rr_troca[i]));
        end

        // Lone requester keeps the bus indefinitely.
        do_reset();
        bus.req = 6'b100000;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("solo_ctrl",  32'(bus.ctrl),  32'h20);
            chk("solo_troca", 32'(bus.troca), 32'(i == 0));
        end
        chk("solo_dono", 32'(bus.dono), 32'd5);

        // Owner 2 drops early; source 4 waiting gets the bus after one idle cycle.
        do_reset();
        bus.req = 6'b010100;
        tick();
        tick();
        chk("drop_pre", 32'(bus.ctrl), 32'h04);
        bus.req = 6'b010000;
        tick();
        chk("drop_idle",      32'(bus.ctrl),    32'h0);
        chk("drop_idle_ocup", 32'(bus.ocupado), 32'h0);
        chk("drop_idle_dono", 32'(bus.dono),    32'd2);
        tick();
        chk("drop_next",  32'(bus.ctrl),  32'h10);
        chk("drop_troca", 32'(bus.troca), 32'h1);

        // Same release with 1,3,4 pending: pointer now 3, so 3 wins over 1 and 4.
        do_reset();
        bus.req = 6'b010100;
        tick();
        tick();
        bus.req = 6'b011010;
        tick();
        chk("ptr3_idle", 32'(bus.ctrl), 32'h0);
        tick();
        chk("ptr3_grant", 32'(bus.ctrl), 32'h08);
        chk("ptr3_dono",  32'(bus.dono), 32'd3);

        // Move pointer to 3, then reset in the middle of a grant.
        do_reset();
        bus.req = 6'b000100;
        tick();
        bus.req = 6'b000000;
        tick();
        tick();
        bus.req = 6'b001000;
        tick();
        chk("pre_rst_grant", 32'(bus.ctrl), 32'h08);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", 32'(bus.ctrl),    32'h0);
        chk("async_rst_ocup", 32'(bus.ocupado), 32'h0);
        chk("async_rst_dono", 32'(bus.dono),    32'h0);
        bus.req = 6'b010010;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ptr0", 32'(bus.ctrl), 32'h02);
        chk("post_rst_dono", 32'(bus.dono), 32'd1);

        // Source 5 owns the bus when source 0 starts requesting.
        do_reset();
        bus.req = 6'b100000;
        tick();
        chk("pr_owner5", 32'(bus.ctrl), 32'h20);
        bus.req = 6'b100001;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("pr_ctrl", 32'(bus.ctrl), 32'(pr_ctrl[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
